mlp_train_sequencer: RTL and testbench

MLP_TRAIN_SEQUENCER -- requirements
Module: mlp_train_sequencer

---
 rtl/Common.sv | 12 +
 rtl/FixedPoint.sv | 27 ++
 rtl/seq_loss_acc.sv | 40 ++++
 rtl/mlp_train_sequencer.sv | 117 +++++++++++
 tb/tb_mlp_train_sequencer.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/Common.sv
// Types shared across the MLP training blocks.
package Common;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SETTLE = 3'd2,
        UPDATE = 3'd3,
        DONE   = 3'd4
    } train_seq_state_t;

endpackage

// File: rtl/FixedPoint.sv
// Signed Q8.8 fixed-point type and saturating helpers shared by the training datapath.
package FixedPoint;

    localparam int SFP_W    = 16;
    localparam int SFP_FRAC = 8;

    typedef logic signed [SFP_W-1:0] sfp;

    localparam sfp SFP_MAX = {1'b0, {(SFP_W-1){1'b1}}};
    localparam sfp SFP_MIN = {1'b1, {(SFP_W-1){1'b0}}};

    function automatic sfp sfp_add(input sfp a, input sfp b);
        logic signed [SFP_W:0] s;
        s = {a[SFP_W-1], a} + {b[SFP_W-1], b};
        // A sign mismatch between the two top bits means the sum left the Q8.8 range
        if (s[SFP_W] != s[SFP_W-1])
            return s[SFP_W] ? SFP_MIN : SFP_MAX;
        return s[SFP_W-1:0];
    endfunction

    function automatic sfp sfp_abs(input sfp a);
        if (a == SFP_MIN)
            return SFP_MAX;
        return a[SFP_W-1] ? -a : a;
    endfunction

endpackage

// File: rtl/seq_loss_acc.sv
// Purpose: sums |error| over the UPDATE cycles of one epoch and reports the total.
// Latency: report appears the cycle after the epoch's last update, loss_valid for 1 cycle.
// Backpressure: none; report is a strobe and epoch_loss holds until the next one.
module seq_loss_acc
    import FixedPoint::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic acc_en,
    input  logic epoch_end,
    input  sfp   err_abs,
    output sfp   epoch_loss,
    output logic loss_valid
);

    sfp acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc        <= '0;
            epoch_loss <= '0;
            loss_valid <= 1'b0;
        end else begin
            loss_valid <= 1'b0;
            if (clr) begin
                acc <= '0;
            end else if (acc_en) begin
                if (epoch_end) begin
                    epoch_loss <= sfp_add(acc, err_abs);
                    loss_valid <= 1'b1;
                    acc        <= '0;
                end else begin
                    acc <= sfp_add(acc, err_abs);
                end
            end
        end
    end

endmodule

// File: rtl/mlp_train_sequencer.sv
// Purpose: steps an MLP through LOAD/SETTLE/UPDATE per sample over all epochs; EPOCH_LOSS_EN adds loss reporting.
// Latency: SETTLE_CYCLES+2 cycles per sample, plus one DONE cycle at the end of the run.
// Backpressure: none; abort returns to IDLE on the next cycle from any busy state.
module mlp_train_sequencer
    import Common::*;
    import FixedPoint::*;
#(
    parameter int NUM_SAMPLES   = 4,
    parameter int NUM_EPOCHS    = 1000,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic abort,
    input  sfp   lr_init,
    input  sfp   error,
    output logic [((NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1)-1:0] sample_addr,
    output logic training,
    output sfp   learning_rate,
    output logic [$clog2(NUM_EPOCHS+1)-1:0] epoch,
    output logic busy,
    output logic done,
    output logic loss_valid,
    output sfp   epoch_loss
);

    localparam int AW = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
    localparam int EW = $clog2(NUM_EPOCHS+1);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [AW-1:0] LAST_SAMPLE = AW'(NUM_SAMPLES-1);
    localparam logic [EW-1:0] LAST_EPOCH  = EW'(NUM_EPOCHS-1);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES-1);

    train_seq_state_t state, state_nxt;
    logic [SW-1:0]    settle_cnt;
    logic             run_go;
    logic             last_sample;
    logic             last_epoch;

    assign run_go      = (state == IDLE) && start && !abort;
    assign last_sample = (sample_addr == LAST_SAMPLE);
    assign last_epoch  = (epoch == LAST_EPOCH);

    assign busy     = (state == LOAD) || (state == SETTLE) || (state == UPDATE);
    // Gating with abort keeps the aborting cycle from committing a weight update
    assign training = (state == UPDATE) && !abort;
    assign done     = (state == DONE) && !abort;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (run_go) state_nxt = LOAD;
            LOAD:    state_nxt = SETTLE;
            SETTLE:  if (settle_cnt == '0) state_nxt = UPDATE;
            UPDATE:  state_nxt = (last_sample && last_epoch) ? DONE : LOAD;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (state != IDLE && abort)
            state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            settle_cnt    <= '0;
            sample_addr   <= '0;
            epoch         <= '0;
            learning_rate <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (run_go) begin
                        sample_addr   <= '0;
                        epoch         <= '0;
                        learning_rate <= lr_init;
                    end
                end
                LOAD:   settle_cnt <= SETTLE_LOAD;
                SETTLE: if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
                UPDATE: begin
                    if (!abort) begin
                        if (!last_sample) begin
                            sample_addr <= sample_addr + 1'b1;
                        end else if (!last_epoch) begin
                            sample_addr <= '0;
                            epoch       <= epoch + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef EPOCH_LOSS_EN
    seq_loss_acc u_loss_acc (
        .clk        (clk),
        .rst        (rst),
        .clr        (run_go),
        .acc_en     (training),
        .epoch_end  (last_sample),
        .err_abs    (sfp_abs(error)),
        .epoch_loss (epoch_loss),
        .loss_valid (loss_valid)
    );
`else
    logic unused_error;
    assign unused_error = ^error;
    assign epoch_loss   = '0;
    assign loss_valid   = 1'b0;
`endif

endmodule

// File: tb/tb_mlp_train_sequencer.sv
// Directed bench for mlp_train_sequencer with NUM_SAMPLES=4, NUM_EPOCHS=2, SETTLE_CYCLES=2.
module tb_mlp_train_sequencer;
    import FixedPoint::*;

    localparam int NS = 4;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    sfp         lr_init;
    sfp         error;
    logic [1:0] sample_addr;
    logic       training;
    sfp         learning_rate;
    logic [1:0] epoch;
    logic       busy;
    logic       done;
    logic       loss_valid;
    sfp         epoch_loss;

    int n_checks = 0;
    int n_errors = 0;

    int trn_cnt  = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int lv_cnt   = 0;
    sfp         last_loss = '0;
    logic [1:0] addr_log [16];
    logic [1:0] ep_log   [16];

    mlp_train_sequencer #(
        .NUM_SAMPLES   (NS),
        .NUM_EPOCHS    (2),
        .SETTLE_CYCLES (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .lr_init       (lr_init),
        .error         (error),
        .sample_addr   (sample_addr),
        .training      (training),
        .learning_rate (learning_rate),
        .epoch         (epoch),
        .busy          (busy),
        .done          (done),
        .loss_valid    (loss_valid),
        .epoch_loss    (epoch_loss)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (training) begin
            if (trn_cnt < 16) begin
                addr_log[trn_cnt] = sample_addr;
                ep_log[trn_cnt]   = epoch;
            end
            trn_cnt++;
        end
        if (busy) busy_cnt++;
        if (done) done_cnt++;
        if (loss_valid) begin
            lv_cnt++;
            last_loss = epoch_loss;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic pulse_start(input sfp lr);
        start   = 1'b1;
        lr_init = lr;
        @(negedge clk);
        start = 1'b0;
    endtask

    int t0, b0, d0, l0;

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        lr_init = '0;
        error   = 16'shFFC0;   // -0.25
        repeat (3) @(negedge clk);
        chk("rst_busy",  busy, 0);
        chk("rst_done",  done, 0);
        chk("rst_train", training, 0);
        chk("rst_addr",  sample_addr, 0);
        chk("rst_epoch", epoch, 0);
        chk("rst_lr",    learning_rate, 0);
        chk("rst_lv",    loss_valid, 0);
        chk("rst_loss",  epoch_loss, 0);
        rst = 1'b0;
        @(negedge clk);

        // Full run; start re-asserted and lr_init changed while busy
        t0 = trn_cnt; b0 = busy_cnt; d0 = done_cnt; l0 = lv_cnt;
        pulse_start(16'sd26);   // 0.1
        repeat (10) @(negedge clk);
        pulse_start(16'sd100);
        chk("lr_mid", learning_rate, 26);
        for (int i = 0; i < 200 && done_cnt == d0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("run_busy", busy_cnt - b0, 32);
        chk("run_train", trn_cnt - t0, 8);
        chk("run_done", done_cnt - d0, 1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("addr%0d", i), addr_log[i], i % 4);
            chk($sformatf("ep%0d", i), ep_log[i], i / 4);
        end
        chk("epoch_hold", epoch, 1);
        chk("lr_after", learning_rate, 26);
        chk("idle_busy", busy, 0);
`ifdef EPOCH_LOSS_EN
        chk("lv_cnt", lv_cnt - l0, 2);
        chk("loss_val", last_loss, NS * 64);
        chk("loss_hold", epoch_loss, NS * 64);
`else
        chk("lv_cnt", lv_cnt - l0, 0);
        chk("loss_zero", epoch_loss, 0);
`endif

        // start together with abort in IDLE must not launch a run
        b0 = busy_cnt; t0 = trn_cnt;
        abort = 1'b1;
        pulse_start(16'sd100);
        abort = 1'b0;
        repeat (8) @(negedge clk);
        chk("sa_busy", busy_cnt - b0, 0);
        chk("sa_train", trn_cnt - t0, 0);
        chk("sa_lr", learning_rate, 26);

        // Abort during SETTLE of sample 1
        t0 = trn_cnt; d0 = done_cnt;
        pulse_start(16'sd64);
        repeat (5) @(negedge clk);
        chk("ab_pre_busy", busy, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_busy", busy, 0);
        chk("ab_train", trn_cnt - t0, 1);
        repeat (6) @(negedge clk);
        chk("ab_idle", busy, 0);
        chk("ab_done", done_cnt - d0, 0);
        chk("ab_lr", learning_rate, 64);

        // Asynchronous reset during SETTLE of sample 2
        t0 = trn_cnt;
        pulse_start(16'sd32);
        repeat (9) @(negedge clk);
        chk("rr_addr", sample_addr, 2);
        chk("rr_pre_train", trn_cnt - t0, 2);
        #1 rst = 1'b1;
        #1;
        chk("rr_busy", busy, 0);
        chk("rr_addr0", sample_addr, 0);
        chk("rr_lr", learning_rate, 0);
        chk("rr_train", training, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("rr_post_train", trn_cnt - t0, 2);
        chk("rr_post_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
